// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit: FSM states,
// instruction classes, opcode values, ALU function selects, instruction
// field positions and an immediate sign-extension helper.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        IC_ADD, IC_SUB, IC_AND, IC_ORR,
        IC_ADDI, IC_SUBI,
        IC_LDUR, IC_STUR,
        IC_CBZ, IC_CBNZ,
        IC_B,
        IC_ILL
    } iclass_t;

    // Opcodes, grouped by the width of the opcode field they occupy
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    // ALU function selects
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    // Instruction field positions
    localparam int OPC11_LSB = 21;
    localparam int OPC10_LSB = 22;
    localparam int OPC8_LSB  = 24;
    localparam int OPC6_LSB  = 26;
    localparam int REG_W     = 5;
    localparam int RD_LSB    = 0;
    localparam int RT_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int RM_LSB    = 16;
    localparam int IMM12_LSB = 10;
    localparam int IMM12_W   = 12;
    localparam int IMM9_LSB  = 12;
    localparam int IMM9_W    = 9;
    localparam int IMM19_LSB = 5;
    localparam int IMM19_W   = 19;
    localparam int IMM26_LSB = 0;
    localparam int IMM26_W   = 26;

    // Sign-extend the low 'width' bits of 'field' to 64 bits
    function automatic logic [63:0] sign_extend(input logic [25:0] field, input int width);
        logic [63:0] ext_mask;
        logic [63:0] sign_mask;
        logic [63:0] raw;
        raw       = 64'(field);
        ext_mask  = {64{1'b1}} << width;
        sign_mask = 64'd1 << (width - 1);
        return (|(raw & sign_mask)) ? (raw | ext_mask) : (raw & ~ext_mask);
    endfunction

endpackage

// File: rtl/legv8_pc_unit.sv
// Program counter for the LEGv8 control unit: holds the PC, advances by 4
// or by a branch offset when told to, freezes otherwise. During reset the
// output already shows the reset value so the imem address is clean.
module legv8_pc_unit #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                advance,
    input  logic                take_branch,
    input  logic [PC_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] pc_next;

    // Sequential or branch target, wrapping silently at the top
    always_comb begin
        pc_next = pc_reg + (take_branch ? branch_offset : PC_WIDTH'(4));
    end

    // PC register: reset load, advance on instruction retire, else hold
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg <= PC_RESET;
        end else if (advance) begin
            pc_reg <= pc_next;
        end
    end

    assign pc = reset ? PC_RESET : pc_reg;

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control FSM (FETCH -> DECODE -> EXEC -> [MEM] -> FETCH,
// plus HALT). Control outputs are combinational decodes of (state, IR) and
// are forced to zero while reset is high so an aborted store never writes.
// Optional build macro LEGV8_CTRL_CBNZ_EN: when defined CBNZ is executed
// (branch on Z=0); when undefined CBNZ is an illegal opcode and halts.
module legv8_control_unit
    import legv8_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [31:0]         instr,
    input  logic [3:0]          status,
    output logic [4:0]          SA,
    output logic [4:0]          SB,
    output logic [4:0]          DA,
    output logic [4:0]          FS,
    output logic                Cin,
    output logic [63:0]         k,
    output logic                selbork,
    output logic                W,
    output logic                writeEn,
    output logic                readEn,
    output logic                triSelBtoD,
    output logic                triSelFtoD,
    output logic                triSelFtoA,
    output logic                triSelOuttoD,
    output logic                halted
);

    state_t      state_reg;
    logic [31:0] ir_reg;
    logic        halted_reg;
    iclass_t     iclass;
    logic [4:0]  alu_fs;
    logic        alu_cin;
    logic [4:0]  rd, rn, rm, rt;
    logic [63:0] imm12_k;
    logic [63:0] imm9_k;
    logic [63:0] br_off64;
    logic        pc_adv;
    logic        pc_branch;
    logic        unused_status;

    // Only the Z flag steers control; the other flags are datapath-only
    assign unused_status = ^status[3:1];

    // Classify the held instruction and pull out its fields
    always_comb begin
        iclass = IC_ILL;
        if (ir_reg[OPC11_LSB +: 11] == OP_ADD)       iclass = IC_ADD;
        else if (ir_reg[OPC11_LSB +: 11] == OP_SUB)  iclass = IC_SUB;
        else if (ir_reg[OPC11_LSB +: 11] == OP_AND)  iclass = IC_AND;
        else if (ir_reg[OPC11_LSB +: 11] == OP_ORR)  iclass = IC_ORR;
        else if (ir_reg[OPC11_LSB +: 11] == OP_LDUR) iclass = IC_LDUR;
        else if (ir_reg[OPC11_LSB +: 11] == OP_STUR) iclass = IC_STUR;
        else if (ir_reg[OPC10_LSB +: 10] == OP_ADDI) iclass = IC_ADDI;
        else if (ir_reg[OPC10_LSB +: 10] == OP_SUBI) iclass = IC_SUBI;
        else if (ir_reg[OPC8_LSB +: 8] == OP_CBZ)    iclass = IC_CBZ;
`ifdef LEGV8_CTRL_CBNZ_EN
        else if (ir_reg[OPC8_LSB +: 8] == OP_CBNZ)   iclass = IC_CBNZ;
`endif
        else if (ir_reg[OPC6_LSB +: 6] == OP_B)      iclass = IC_B;

        rd = ir_reg[RD_LSB +: REG_W];
        rt = ir_reg[RT_LSB +: REG_W];
        rn = ir_reg[RN_LSB +: REG_W];
        rm = ir_reg[RM_LSB +: REG_W];

        imm12_k = 64'(ir_reg[IMM12_LSB +: IMM12_W]);
        imm9_k  = sign_extend(26'(ir_reg[IMM9_LSB +: IMM9_W]), IMM9_W);
        if (iclass == IC_B) begin
            br_off64 = sign_extend(ir_reg[IMM26_LSB +: IMM26_W], IMM26_W) << 2;
        end else begin
            br_off64 = sign_extend(26'(ir_reg[IMM19_LSB +: IMM19_W]), IMM19_W) << 2;
        end

        alu_fs  = FS_ADD;
        alu_cin = 1'b0;
        case (iclass)
            IC_SUB, IC_SUBI: begin
                alu_fs  = FS_SUB;
                alu_cin = 1'b1;
            end
            IC_AND:  alu_fs = FS_AND;
            IC_ORR:  alu_fs = FS_ORR;
            default: alu_fs = FS_ADD;
        endcase
    end

    // Datapath control word and PC advance, decoded from state and IR
    always_comb begin
        SA           = '0;
        SB           = '0;
        DA           = '0;
        FS           = '0;
        Cin          = 1'b0;
        k            = '0;
        selbork      = 1'b0;
        W            = 1'b0;
        writeEn      = 1'b0;
        readEn       = 1'b0;
        triSelBtoD   = 1'b0;
        triSelFtoD   = 1'b0;
        triSelFtoA   = 1'b0;
        triSelOuttoD = 1'b0;
        halted       = 1'b0;
        pc_adv       = 1'b0;
        pc_branch    = 1'b0;
        if (!reset) begin
            halted = halted_reg;
            case (state_reg)
                ST_EXEC: begin
                    case (iclass)
                        IC_ADD, IC_SUB, IC_AND, IC_ORR: begin
                            SA         = rn;
                            SB         = rm;
                            DA         = rd;
                            FS         = alu_fs;
                            Cin        = alu_cin;
                            W          = 1'b1;
                            triSelFtoD = 1'b1;
                            pc_adv     = 1'b1;
                        end
                        IC_ADDI, IC_SUBI: begin
                            SA         = rn;
                            DA         = rd;
                            FS         = alu_fs;
                            Cin        = alu_cin;
                            k          = imm12_k;
                            selbork    = 1'b1;
                            W          = 1'b1;
                            triSelFtoD = 1'b1;
                            pc_adv     = 1'b1;
                        end
                        IC_LDUR, IC_STUR: begin
                            SA         = rn;
                            k          = imm9_k;
                            selbork    = 1'b1;
                            FS         = FS_ADD;
                            triSelFtoA = 1'b1;
                        end
                        IC_CBZ, IC_CBNZ: begin
                            SA        = rt;
                            selbork   = 1'b1;
                            FS        = FS_ADD;
                            pc_adv    = 1'b1;
                            pc_branch = (iclass == IC_CBZ) ? status[0] : ~status[0];
                        end
                        IC_B: begin
                            pc_adv    = 1'b1;
                            pc_branch = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    // Address path held from EXEC so the RAM address is stable
                    SA         = rn;
                    k          = imm9_k;
                    selbork    = 1'b1;
                    FS         = FS_ADD;
                    triSelFtoA = 1'b1;
                    pc_adv     = 1'b1;
                    if (iclass == IC_LDUR) begin
                        readEn       = 1'b1;
                        triSelOuttoD = 1'b1;
                        DA           = rt;
                        W            = 1'b1;
                    end else begin
                        SB         = rt;
                        triSelBtoD = 1'b1;
                        writeEn    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer: state, instruction register and sticky halt flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_FETCH;
            ir_reg     <= '0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH:  state_reg <= ST_DECODE;
                ST_DECODE: begin
                    ir_reg    <= instr;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (iclass)
                        IC_LDUR, IC_STUR: state_reg <= ST_MEM;
                        IC_ILL: begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end
                        default: state_reg <= ST_FETCH;
                    endcase
                end
                ST_MEM:  state_reg <= ST_FETCH;
                ST_HALT: state_reg <= ST_HALT;
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

    legv8_pc_unit #(
        .PC_WIDTH (PC_WIDTH),
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clock         (clock),
        .reset         (reset),
        .advance       (pc_adv),
        .take_branch   (pc_branch),
        .branch_offset (br_off64[PC_WIDTH-1:0]),
        .pc            (pc)
    );

endmodule

// File: tb/tb_legv8_control_unit.sv
// Self-checking bench for legv8_control_unit. A small program is run from
// a bench-side instruction memory; an instruction-level model expands each
// fetched instruction into its expected per-cycle control words and a
// compare process checks the DUT on every falling edge.
module tb_legv8_control_unit;

    logic        clock;
    logic        reset;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [3:0]  status;
    logic [4:0]  SA, SB, DA, FS;
    logic        Cin;
    logic [63:0] k;
    logic        selbork, W, writeEn, readEn;
    logic        triSelBtoD, triSelFtoD, triSelFtoA, triSelOuttoD, halted;

    int total = 0;
    int bad   = 0;
    int cyc   = -1;

    logic [31:0] mem [0:31];

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] k;
        logic [4:0]  sa, sb, da, fs;
        logic        cin, selbork, w, we, re, btod, ftod, ftoa, outtod, halted;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_pc     = 64'd0;
    logic        model_halted = 1'b0;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_ADDI = 4, K_SUBI = 5;
    localparam int K_LDUR = 6, K_STUR = 7, K_CBZ = 8, K_CBNZ = 9, K_B = 10, K_ILL = 11;

    legv8_control_unit dut (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .instr        (instr),
        .status       (status),
        .SA           (SA),
        .SB           (SB),
        .DA           (DA),
        .FS           (FS),
        .Cin          (Cin),
        .k            (k),
        .selbork      (selbork),
        .W            (W),
        .writeEn      (writeEn),
        .readEn       (readEn),
        .triSelBtoD   (triSelBtoD),
        .triSelFtoD   (triSelFtoD),
        .triSelFtoA   (triSelFtoA),
        .triSelOuttoD (triSelOuttoD),
        .halted       (halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous instruction memory: data appears one cycle after address
    initial begin
        instr = 32'd0;
        forever begin
            @(posedge clock);
            instr <= mem[pc[6:2]];
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, input logic [4:0] rd);
        return {op, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm, input logic [4:0] rt);
        return {op, imm, rt};
    endfunction

    // ---------------- instruction-level model ----------------
    function automatic int kind(input logic [31:0] ir);
        casez (ir)
            {11'b10001011000, 21'b?}: return K_ADD;
            {11'b11001011000, 21'b?}: return K_SUB;
            {11'b10001010000, 21'b?}: return K_AND;
            {11'b10101010000, 21'b?}: return K_ORR;
            {10'b1001000100, 22'b?}:  return K_ADDI;
            {10'b1101000100, 22'b?}:  return K_SUBI;
            {11'b11111000010, 21'b?}: return K_LDUR;
            {11'b11111000000, 21'b?}: return K_STUR;
            {8'b10110100, 24'b?}:     return K_CBZ;
`ifdef LEGV8_CTRL_CBNZ_EN
            {8'b10110101, 24'b?}:     return K_CBNZ;
`endif
            {6'b000101, 26'b?}:       return K_B;
            default:                  return K_ILL;
        endcase
    endfunction

    function automatic exp_t zero_word(input logic [63:0] p);
        exp_t e;
        e    = '0;
        e.pc = p;
        return e;
    endfunction

    function automatic exp_t exec_word(input logic [31:0] ir, input logic [63:0] p);
        exp_t   e;
        int     kd;
        longint off;
        e  = zero_word(p);
        kd = kind(ir);
        case (kd)
            K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI: begin
                e.sa   = ir[9:5];
                e.da   = ir[4:0];
                e.w    = 1'b1;
                e.ftod = 1'b1;
                e.cin  = (kd == K_SUB || kd == K_SUBI);
                e.fs   = (kd == K_SUB || kd == K_SUBI) ? 5'b01001 :
                         (kd == K_AND) ? 5'b00000 :
                         (kd == K_ORR) ? 5'b00100 : 5'b01000;
                if (kd == K_ADDI || kd == K_SUBI) begin
                    e.selbork = 1'b1;
                    e.k       = 64'(ir[21:10]);
                end else begin
                    e.sb = ir[20:16];
                end
            end
            K_LDUR, K_STUR: begin
                off = longint'(ir[20:12]);
                if (off >= 256) off = off - 512;
                e.sa      = ir[9:5];
                e.k       = 64'(off);
                e.selbork = 1'b1;
                e.fs      = 5'b01000;
                e.ftoa    = 1'b1;
            end
            K_CBZ, K_CBNZ: begin
                e.sa      = ir[4:0];
                e.selbork = 1'b1;
                e.fs      = 5'b01000;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t mem_word(input logic [31:0] ir, input logic [63:0] p);
        exp_t e;
        e = exec_word(ir, p);
        if (kind(ir) == K_LDUR) begin
            e.re     = 1'b1;
            e.outtod = 1'b1;
            e.da     = ir[4:0];
            e.w      = 1'b1;
        end else begin
            e.sb   = ir[4:0];
            e.btod = 1'b1;
            e.we   = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [63:0] next_pc(input logic [31:0] ir, input logic [63:0] p, input logic z);
        longint off;
        case (kind(ir))
            K_CBZ, K_CBNZ: begin
                off = longint'(ir[23:5]);
                if (off >= 262144) off = off - 524288;
                if ((kind(ir) == K_CBZ) ? z : !z) return p + 64'(off * 4);
                return p + 64'd4;
            end
            K_B: begin
                off = longint'(ir[25:0]);
                if (off >= 33554432) off = off - 67108864;
                return p + 64'(off * 4);
            end
            K_ILL:   return p;
            default: return p + 64'd4;
        endcase
    endfunction

    task automatic model_issue();
        logic [31:0] ir;
        ir = mem[model_pc[6:2]];
        exp_q.push_back(zero_word(model_pc));
        exp_q.push_back(zero_word(model_pc));
        exp_q.push_back(exec_word(ir, model_pc));
        if (kind(ir) == K_LDUR || kind(ir) == K_STUR) exp_q.push_back(mem_word(ir, model_pc));
        if (kind(ir) == K_ILL) model_halted = 1'b1;
        model_pc = next_pc(ir, model_pc, status[0]);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, req);
        end
    endtask

    // Per-cycle compare of the DUT against the model
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                model_pc     = 64'd0;
                model_halted = 1'b0;
                e            = zero_word(64'd0);
            end else begin
                if (exp_q.size() == 0 && !model_halted) model_issue();
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e        = zero_word(model_pc);
                    e.halted = 1'b1;
                end
            end
            check("pc", pc, e.pc);
            check("regsel", {SA, SB, DA}, {e.sa, e.sb, e.da});
            check("fs_cin", {FS, Cin}, {e.fs, e.cin});
            check("k", k, e.k);
            check("ctl", {selbork, W, writeEn, readEn, triSelBtoD, triSelFtoD, triSelFtoA, triSelOuttoD},
                  {e.selbork, e.w, e.we, e.re, e.btod, e.ftod, e.ftoa, e.outtod});
            check("halted", halted, e.halted);
            total++;
            if ($countones({triSelBtoD, triSelFtoD, triSelOuttoD}) > 1) begin
                bad++;
                $display("FAIL dbus_drivers t=%0t got=%b expected at most one set", $time,
                         {triSelBtoD, triSelFtoD, triSelOuttoD});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_program();
        for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
        mem[0] = 32'h9100_1401;                                  // ADDI X1,X0,#5
        mem[1] = enc_d(11'b11111000000, 9'h1F8, 5'd1, 5'd2);     // STUR X2,[X1,#-8]
        mem[2] = enc_d(11'b11111000010, 9'h1F8, 5'd1, 5'd3);     // LDUR X3,[X1,#-8]
        mem[3] = enc_i(10'b1101000100, 12'd100, 5'd1, 5'd9);     // SUBI X9,X1,#100
        mem[4] = enc_cb(8'b10110100, 19'd3, 5'd4);               // CBZ X4,#+3
        mem[5] = enc_r(11'b11001011000, 5'd3, 5'd1, 5'd10);      // SUB X10,X1,X3
        mem[6] = enc_r(11'b10001010000, 5'd5, 5'd2, 5'd11);      // AND X11,X2,X5
        mem[7] = enc_r(11'b10101010000, 5'd7, 5'd6, 5'd12);      // ORR X12,X6,X7
        mem[8] = {6'b000101, 26'h3FF_FFFC};                      // B #-4
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic start_run(input logic z);
        @(posedge clock);
        #1 reset = 1'b1;
        status = {3'b101, z};
        load_program();
    endtask

    task automatic release_reset();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc = -1;
    endtask

    initial begin
        exp_t pin;
        reset  = 1'b1;
        status = 4'b0000;
        load_program();

        // Hand-computed pins on the model itself
        pin = exec_word(32'h9100_1401, 64'd0);
        check("model_addi", {pin.k, pin.da, pin.fs}, {64'd5, 5'd1, 5'b01000});
        pin = exec_word(mem[1], 64'd4);
        check("model_stur_k", pin.k, 64'hFFFF_FFFF_FFFF_FFF8);
        check("model_cbz_taken", next_pc(mem[4], 64'h10, 1'b1), 64'h1C);
        check("model_cbz_not", next_pc(mem[4], 64'h10, 1'b0), 64'h14);
        check("model_b", next_pc(mem[8], 64'h20, 1'b0), 64'h10);

        // Run 1: reset for 3 cycles, Z=0
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        cyc = -1;
        step_to(0);  check("fetch_pc0", pc, 64'd0);
        step_to(2);
        check("addi_sel", {SA, DA}, {5'd0, 5'd1});
        check("addi_k", k, 64'd5);
        check("addi_ctl", {selbork, W, triSelFtoD, FS}, {3'b111, 5'b01000});
        step_to(3);  check("addi_pc", pc, 64'd4);
        step_to(5);  check("stur_exec", {k, triSelFtoA}, {64'hFFFF_FFFF_FFFF_FFF8, 1'b1});
        step_to(6);  check("stur_mem", {writeEn, triSelBtoD, SB}, {2'b11, 5'd2});
        step_to(10); check("ldur_mem", {readEn, triSelOuttoD, W, DA}, {3'b111, 5'd3});
        step_to(14); check("cbz_pc", pc, 64'h10);
        step_to(17); check("cbz_not_taken", pc, 64'h14);
        step_to(29); check("b_target", pc, 64'h10);
        step_to(60);

        // Run 2: Z=1, ADD in place of ORR
        start_run(1'b1);
        mem[7] = enc_r(11'b10001011000, 5'd15, 5'd14, 5'd13);   // ADD X13,X14,X15
        release_reset();
        step_to(17); check("cbz_taken", pc, 64'h1C);
        step_to(23); check("b_after_add", pc, 64'h10);
        step_to(50);

        // Run 3: illegal opcode halts and freezes the PC
        start_run(1'b0);
        mem[3] = 32'hFFFF_FFFF;
        release_reset();
        step_to(14); check("halt_flag", {halted, pc}, {1'b1, 64'h0C});
        step_to(30); check("halt_frozen", {halted, pc}, {1'b1, 64'h0C});

        // Run 3b: CBNZ (executes or halts depending on the build)
        start_run(1'b0);
        mem[3] = enc_cb(8'b10110101, 19'd2, 5'd4);
        release_reset();
        step_to(30);

        // Run 4: reset arrives during the store MEM cycle
        start_run(1'b0);
        release_reset();
        step_to(5);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_mem_we", {writeEn, triSelBtoD}, 2'b00);
        check("rst_mem_pc", pc, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc = -1;
        step_to(3);  check("rst_restart_pc", pc, 64'd4);
        step_to(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle LEGv8 control FSM, directly upstream of the memory-equipped datapath.
- Fetches 32-bit instructions from a synchronous instruction memory and holds them in an IR.
- Each cycle, drives the full datapath control word: register selects, FS/Cin, constant k, bus tri-state selects, RAM read/write enables.
- Owns the PC; resolves CBZ and B from datapath status.

Parameters:
- PC_WIDTH, 64, width of program counter and imem address.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc  out  PC_WIDTH  instruction memory address.
- instr  in  32  imem read data; valid one cycle after pc is presented.
- status  in  4  datapath ALU flags: [0]=Z, [1]=N, [2]=C, [3]=V.
- SA, SB, DA  out  5 each  register file read A / read B / write selects.
- FS  out  5  ALU function select.
- Cin  out  1  ALU carry-in.
- k  out  64  constant operand.
- selbork  out  1  1 = ALU B operand is k.
- W  out  1  register file write enable.
- writeEn, readEn  out  1 each  RAM enables.
- triSelBtoD, triSelFtoD, triSelFtoA, triSelOuttoD  out  1 each  bus drivers.
- halted  out  1  illegal opcode seen.

Behaviour:
- Reset: one clock and one synchronous active-high reset.
  - Outputs on reset: pc=PC_RESET, state=FETCH, halted=0, IR=0, every control output 0.
  - Zero control outputs mean no bus drivers and no writes.
  - Reset asserted mid-instruction aborts it; no write occurs in the reset cycle.
- States: FETCH -> DECODE -> EXEC -> (MEM) -> FETCH; HALT.
- All control outputs are registered-free decodes of (state, IR).
- FETCH: pc stable, all control 0. Next state DECODE.
- DECODE: IR <= instr, all control 0. Next state EXEC.
- EXEC (default for all opcodes: W=0 and all enables 0, except as listed):
  - R-type ADD/SUB/AND/ORR: SA=Rn[9:5], SB=Rm[20:16], DA=Rd[4:0], selbork=0, FS per op, W=1, triSelFtoD=1. Then pc+=4, next FETCH.
  - ADDI/SUBI: as R-type but selbork=1, k=zero-extended imm12[21:10].
  - LDUR/STUR: SA=Rn, k=sign-extended imm9[20:12], selbork=1, FS=FS_ADD, triSelFtoA=1. Next MEM.
  - CBZ: SA=Rt[4:0], selbork=1, k=0, FS=FS_ADD. Sample status[0] in this cycle.
    - Z=1: pc += sext(imm19[23:5])<<2.
    - Z=0: pc += 4.
    - Next FETCH.
  - B: pc += sext(imm26)<<2, no datapath activity. Next FETCH.
  - Any other opcode: halted<=1, next HALT.
- MEM: SA, k, FS, selbork, triSelFtoA held from EXEC so the address stays stable.
  - LDUR: readEn=1, triSelOuttoD=1, DA=Rt, W=1.
  - STUR: SB=Rt, triSelBtoD=1, writeEn=1.
  - Both: pc+=4, next FETCH.
- HALT: all control 0, pc frozen; only reset exits.
- Opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (bits 31:21).
  - ADDI 1001000100, SUBI 1101000100 (bits 31:22).
  - LDUR 11111000010, STUR 11111000000 (bits 31:21).
  - CBZ 10110100, CBNZ 10110101 (bits 31:24).
  - B 000101 (bits 31:26).
- FS/Cin encodings:
  - AND = 00000, Cin 0.
  - ORR = 00100, Cin 0.
  - ADD = 01000, Cin 0.
  - SUB = 01001, Cin 1.
- PC arithmetic is modulo 2^PC_WIDTH; wrap at the top is silent.
- Bus invariant: at most one of the D drivers (triSelBtoD, triSelFtoD, triSelOuttoD) is 1 in any cycle. The bench asserts this every cycle.

Optional Feature:
- Macro LEGV8_CTRL_CBNZ_EN.
- Defined: CBNZ decodes like CBZ but branches when status[0]=0.
- Undefined: the CBNZ opcode is illegal and goes to HALT with halted=1.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - FS_* constants;
  - instruction field bit positions;
  - an immediate sign-extension function.
- One sub-module, legv8_pc_unit, holds the PC register, +4 / branch-offset adder, reset load and freeze.
- The FSM and decode stay in the top module.

Test Plan:
- Reset held 3 cycles then released -> pc=0 and all controls 0 during reset; FETCH at the first cycle after release.
- ADDI X1,X0,#5 (0x91001401) -> EXEC cycle shows SA=0, DA=1, k=5, selbork=1, FS=01000, W=1, triSelFtoD=1; pc=4 after 3 cycles.
- STUR X2,[X1,#-8] then LDUR X3,[X1,#-8]:
  - store EXEC: k=0xFFFF_FFFF_FFFF_FFF8, triSelFtoA=1.
  - store MEM: writeEn=1, triSelBtoD=1, SB=2.
  - load MEM: readEn=1, triSelOuttoD=1, DA=3, W=1.
- CBZ X4,#+3 at pc=0x10:
  - status[0]=1 -> pc=0x1C.
  - status[0]=0 -> pc=0x14.
- B #-4 at pc=0x20 -> pc=0x10; opcode 0xFFFFFFFF -> halted=1, pc frozen until reset.
- Reset asserted during a store MEM cycle -> writeEn=0 that cycle, pc=0.
- Across all scenarios: never two D-bus drivers active in the same cycle.
